// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - oversampling UART receiver with majority-vote bit decisions and FWFT receive FIFO
module uart_rx_engine #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          baud_tick,
  input  logic                          UART_RX_I,
  input  logic                          Unload_data,
  input  logic                          Clear_errors,
  output logic [DATA_BITS-1:0]          RX_data,
  output logic                          RX_frame_err,
  output logic                          RX_parity_err,
  output logic                          Empty,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          Overrun,
  output logic                          Break_detect
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_V0  = TW'(M - 1);
  localparam logic [TW-1:0] T_V1  = TW'(M);
  localparam logic [TW-1:0] T_V2  = TW'(M + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   C_FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 v0, v1;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_err, parity_err, par_bit;
  logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS+1:0] head;

  logic majority, vote_now, bit_end, frame_done, fe_final, is_break;
  logic push, do_write, do_pop, ovr_set, brk_set;

  assign majority   = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign vote_now   = baud_tick && (tick_cnt == T_V2);
  assign bit_end    = baud_tick && (tick_cnt == T_END);
  assign frame_done = Enable && (state == S_STOP) && vote_now && (bit_cnt == B_STOP_LAST);
  assign fe_final   = frame_err | ~majority;
  // A break is an all-zero frame whose stop bit also reads low; it never enters the FIFO.
  assign is_break   = (shreg == '0) && !par_bit && fe_final;
  assign push       = frame_done && !is_break;
  assign brk_set    = frame_done && is_break;

  assign do_pop   = Unload_data && !Empty;
  assign do_write = push && (!Full || do_pop);
  assign ovr_set  = push && Full && !do_pop;

  assign Empty         = (Count == '0);
  assign Full          = (Count == C_FULL);
  assign head          = mem[rd_ptr];
  assign RX_data       = Empty ? '0 : head[DATA_BITS+1:2];
  assign RX_frame_err  = !Empty && head[1];
  assign RX_parity_err = !Empty && head[0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (Enable && !rx_s) state_n = S_START;
      S_START:  if (vote_now && majority) state_n = S_IDLE;
                else if (bit_end) state_n = S_DATA;
      S_DATA:   if (bit_end && bit_cnt == B_DATA_LAST)
                  state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_n = S_STOP;
      S_STOP:   if (vote_now && bit_cnt == B_STOP_LAST) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (state != S_IDLE && !Enable) state_n = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      v0         <= 1'b1;
      v1         <= 1'b1;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      state <= state_n;
      rx_m  <= UART_RX_I;
      rx_s  <= rx_m;
      if (state == S_IDLE) begin
        tick_cnt   <= '0;
        bit_cnt    <= '0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        par_bit    <= 1'b0;
      end else if (baud_tick) begin
        tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + TW'(1);
        if (tick_cnt == T_V0) v0 <= rx_s;
        if (tick_cnt == T_V1) v1 <= rx_s;
        if (tick_cnt == T_V2) begin
          case (state)
            S_DATA:   shreg <= {majority, shreg[DATA_BITS-1:1]};
            S_PARITY: begin
              par_bit    <= majority;
              parity_err <= (^shreg) ^ majority ^ (PARITY_MODE == 2);
            end
            S_STOP:   if (!majority) frame_err <= 1'b1;
            default:  ;
          endcase
        end
        if (tick_cnt == T_END) begin
          if (state == S_DATA) bit_cnt <= (bit_cnt == B_DATA_LAST) ? '0 : bit_cnt + BW'(1);
          else if (state == S_STOP) bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (do_write) mem[wr_ptr] <= {shreg, fe_final, parity_err};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Count        <= '0;
      Overrun      <= 1'b0;
      Break_detect <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !do_pop)      Count <= Count + (AW + 1)'(1);
      else if (!do_write && do_pop) Count <= Count - (AW + 1)'(1);
      Overrun      <= ovr_set | (Overrun & ~Clear_errors);
      Break_detect <= brk_set | (Break_detect & ~Clear_errors);
    end
  end
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed self-checking bench for uart_rx_engine (8E1, x16, 4-deep FIFO)
module tb_uart_rx_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_line = 1'b1;
  logic       unload = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rx_data;
  logic       fe, pe, empty, full, overrun, brk;
  logic [2:0] count;
  int         n_vec = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  uart_rx_engine #(
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) dut (
    .Clk(clk), .Reset(reset), .Enable(enable), .baud_tick(baud_tick),
    .UART_RX_I(rx_line), .Unload_data(unload), .Clear_errors(clr),
    .RX_data(rx_data), .RX_frame_err(fe), .RX_parity_err(pe),
    .Empty(empty), .Full(full), .Count(count),
    .Overrun(overrun), .Break_detect(brk)
  );

  // One baud_tick every 4 clocks, driven on the falling edge.
  initial begin : baud_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      baud_tick = (div == 0);
      div = (div + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_tick();
    do @(posedge clk); while (!baud_tick);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    rx_line = v;
    repeat (n) next_tick();
  endtask

  // Short stop-bit-low frames release the line just after the stop vote so the re-armed start is rejected.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit glitch);
    next_tick();
    drive(1'b0, 16);
    for (int j = 0; j < 8; j++) begin
      if (glitch && j == 3) begin
        drive(d[j], 8);
        drive(~d[j], 1);
        drive(d[j], 7);
      end else begin
        drive(d[j], 16);
      end
    end
    drive(par, 16);
    drive(stp, stp ? 16 : 11);
    drive(1'b1, 16);
  endtask

  task automatic pulse_unload();
    @(negedge clk);
    unload = 1'b1;
    @(negedge clk);
    unload = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_word;
    repeat (4) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_data", rx_data, 0);
    check("rst_flags", {fe, pe, overrun, brk}, 0);

    pulse_unload();
    check("unload_empty_count", count, 0);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("a5_empty", empty, 0);
    check("a5_count", count, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_flags", {fe, pe}, 0);
    pulse_unload();
    check("a5_pop_empty", empty, 1);
    check("a5_pop_data", rx_data, 0);

    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check("3c_par_data", rx_data, 8'h3C);
    check("3c_par_pe", pe, 1);
    check("3c_par_fe", fe, 0);
    pulse_unload();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("3c_stop_count", count, 1);
    check("3c_stop_data", rx_data, 8'h3C);
    check("3c_stop_fe", fe, 1);
    check("3c_stop_pe", pe, 0);
    pulse_unload();

    next_tick();
    drive(1'b0, 5);
    drive(1'b1, 32);
    check("false_start_count", count, 0);
    check("false_start_flags", {overrun, brk}, 0);

    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1, 1'b0);
    send_frame(8'h04, 1'b1, 1'b1, 1'b0);
    check("fill_ovr_before", overrun, 0);
    send_frame(8'h05, 1'b0, 1'b1, 1'b0);
    check("ovr_count", count, 4);
    check("ovr_full", full, 1);
    check("ovr_flag", overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      exp_word = 8'(k);
      check("ovr_pop_data", rx_data, exp_word);
      pulse_unload();
    end
    check("ovr_drained", empty, 1);
    check("ovr_sticky", overrun, 1);
    pulse_clear();
    check("ovr_cleared", overrun, 0);

    next_tick();
    drive(1'b0, 16 * 12);
    rx_line = 1'b1;
    check("break_flag", brk, 1);
    check("break_count", count, 0);
    drive(1'b1, 16 * 14);
    for (int k = 0; k < 8 && !empty; k++) pulse_unload();
    check("break_flushed", empty, 1);
    pulse_clear();
    check("break_cleared", brk, 0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    check("post_break_data", rx_data, 8'h55);
    check("post_break_flags", {fe, pe}, 0);

    send_frame(8'h6B, 1'b1, 1'b1, 1'b1);
    check("glitch_count", count, 2);
    pulse_unload();
    check("glitch_data", rx_data, 8'h6B);
    check("glitch_flags", {fe, pe}, 0);

    next_tick();
    drive(1'b0, 16);
    exp_word = 8'hF0;
    for (int j = 0; j < 4; j++) drive(exp_word[j], 16);
    drive(exp_word[4], 8);
    reset   = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_empty", empty, 1);
    check("midrst_count", count, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_flags", {full, fe, pe, overrun, brk}, 0);
    drive(1'b1, 16 * 12);
    check("midrst_no_push", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised UART receiver with configurable frame format, 3-sample majority-vote bit decisions, false-start rejection and break detection. Received words enter an on-chip first-word-fall-through FIFO with per-word error flags. It takes the same shared oversampling `baud_tick` strobe as the existing receive controller and replaces it in designs that need multi-word buffering or non-8N1 framing.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..9, LSB first.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `OVERSAMPLE`, 16: `baud_tick` pulses per bit, even, ≥8.
- `FIFO_DEPTH`, 8: entries, power of two, ≥2.

Ports:
- `Clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `Enable` in 1: receiver enable.
- `baud_tick` in 1: one-`Clk` strobe at OVERSAMPLE×baud.
- `UART_RX_I` in 1: asynchronous serial input, idle high.
- `Unload_data` in 1: pop FIFO head.
- `Clear_errors` in 1: clears sticky `Overrun` and `Break_detect`.
- `RX_data` out DATA_BITS: FIFO head data.
- `RX_frame_err` out 1: head word had a bad stop bit.
- `RX_parity_err` out 1: head word failed parity (always 0 when `PARITY_MODE`=0).
- `Empty` out 1, `Full` out 1: FIFO status.
- `Count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `Overrun` out 1: sticky, word dropped because FIFO full.
- `Break_detect` out 1: sticky, break frame seen.

## Operation
- `UART_RX_I` passes a 2-FF synchroniser. Both stages reset to 1. The second stage is `rx_s`.
- `tick_cnt` counts `baud_tick` from 0 to OVERSAMPLE-1, then wraps. Let M = OVERSAMPLE/2.
- Votes: sample `rx_s` on `baud_tick` at `tick_cnt` = M-1, M, M+1. Bit value is the majority of the three.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: if `Enable` and `rx_s`=0, go to START, `tick_cnt`←0, `bit_cnt`←0.
- START: at vote completion (`tick_cnt`=M+1 with `baud_tick`):
  - majority 1: false start, return to IDLE, nothing pushed;
  - majority 0: continue. At `tick_cnt`=OVERSAMPLE-1 with `baud_tick`, go to DATA.
- DATA: shift each majority bit in LSB first. At the end of each bit period increment `bit_cnt`. After bit DATA_BITS-1, go to PARITY if `PARITY_MODE`≠0, else STOP.
- PARITY: compare the voted bit with the expected value.
  - even mode: XOR of data bits and parity bit must equal 0;
  - odd mode: that XOR must equal 1.
  - At the end of the bit period, go to STOP.
- STOP: vote each stop bit. Any voted 0 sets `frame_err`.
  - After the last stop bit vote (`tick_cnt`=M+1 of the final stop bit), the frame completes on that edge and the state returns to IDLE. It does not wait out the bit, so resync is early.
- Frame completion:
  - break = all data bits 0, parity bit (if any) 0, and `frame_err`. On break, set `Break_detect` and push nothing;
  - otherwise push {data, `frame_err`, `parity_err`}.
- FIFO:
  - `RX_data`, `RX_frame_err`, `RX_parity_err` show the head entry and are forced to 0 when `Empty`;
  - `Unload_data` while `Empty` is ignored;
  - push while `Full` with no pop: word discarded, `Overrun`←1;
  - push and pop on the same edge while `Full`: both take effect, `Count` unchanged, no overrun;
  - push and pop on the same edge while `Empty`: the push wins and the pop is ignored.
- `Clear_errors` clears `Overrun`/`Break_detect` on its edge. A set event on the same edge wins.
- `Enable` low mid-frame: abort to IDLE on the next edge, no push, FIFO untouched.
- Reset values: state IDLE, counters 0, FIFO empty. Outputs: `Empty`=1, `Full`=0, `Count`=0, `RX_data`=0, `RX_frame_err`=0, `RX_parity_err`=0, `Overrun`=0, `Break_detect`=0.
- `Reset` mid-frame discards the partial frame and all FIFO contents.

## Timing
- A falling edge on `UART_RX_I` reaches `rx_s` 2 `Clk` later. START is entered on the following edge.
- Push occurs on the `Clk` edge of the final stop-bit vote.
- `Empty`, `Count`, `RX_data` and the flag outputs update on the same edge as the push or pop. They are registered, with no extra cycle.
- `Overrun` and `Break_detect` assert on the frame-completion edge.
- After a frame completes, a new start bit is accepted from the next `Clk` edge.

## Test plan
Defaults for the bench: DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1, OVERSAMPLE=16, FIFO_DEPTH=4.
- Frame 0xA5, even parity bit 0, stop 1. Expect `Empty`→0, `RX_data`=0xA5, both error flags 0. `Unload_data` then gives `Empty`=1, `RX_data`=0.
- Frame 0x3C with parity bit 1. Expect `RX_parity_err`=1, `RX_data`=0x3C. Frame 0x3C with stop bit 0. Expect `RX_frame_err`=1.
- 0-pulse of 5 `baud_tick` on an idle line. Expect return to IDLE, `Count` stays 0, no flags.
- Five frames 0x01..0x05 with no unload. Expect `Count`=4, `Full`=1, `Overrun`=1, and pops return 0x01..0x04. `Clear_errors` then gives `Overrun`=0.
- Line held low for 12 bit periods. Expect `Break_detect`=1, `Count`=0. After the line returns high, a 0x55 frame is received correctly.
- Glitch of 1 `baud_tick` at vote M on data bit 3. Majority preserves the bit. Additionally, assert `Reset` at mid-data-bit 4 of a frame. Expect all outputs at reset values and no push.
